integrate_dump: RTL and testbench
=================================

// Module: integrate_dump
// PURPOSE
//  Integrate-and-dump accumulator directly downstream of the sign/magnitude ->
//  two's-complement extension stage in each correlator arm (I/E, I/P, Q/L...).
//  Sums signed wiped-off samples over one C/A code period, then dumps the total
//  with a one-cycle valid strobe to the tracking-loop / power-estimate logic.
//  Saturates instead of wrapping; flags saturation per period.
// PARAMETERS
//  IN_WIDTH    4   width of signed two's-complement input sample
//  ACC_WIDTH   20  width of signed accumulator and dumped result (> IN_WIDTH)
//  COUNT_WIDTH 16  width of per-period sample counter
// PORTS
//  clk           in   1            sample clock; single clock domain
//  reset         in   1            asynchronous, active-high reset
//  clear         in   1            sync: discard current period, restart at 0
//  sample_valid  in   1            sample qualifies this cycle
//  sample        in   IN_WIDTH     signed two's-complement sample
//  dump          in   1            sync strobe: this cycle closes the period
//  result        out  ACC_WIDTH    signed sum of closed period (held)
//  result_count  out  COUNT_WIDTH  number of samples in closed period (held)
//  result_ovf    out  1            saturation occurred in closed period (held)
//  result_valid  out  1            one-cycle pulse: result* updated
// BEHAVIOUR
//  - Reset (async, any time): acc, count, ovf, result, result_count,
//    result_ovf, result_valid all -> 0. Open period is lost; no dump emitted.
//  - Width: sample sign-extended to ACC_WIDTH+1, added to acc in ACC_WIDTH+1
//    bits; if sum > 2^(ACC_WIDTH-1)-1 clamp to max, if < -2^(ACC_WIDTH-1)
//    clamp to min; either clamp sets sticky ovf for the period. Never wraps.
//  - Counter: count increments per valid sample; saturates at all-ones and
//    sets ovf (no wrap).
//  - Per-cycle priority (registered on rising clk):
//    1) clear=1: acc<=0, count<=0, ovf<=0; result* unchanged, result_valid=0.
//       Any sample_valid/dump same cycle is discarded.
//    2) dump=1: result<=acc (+sample if sample_valid, saturated), result_count
//       <=count(+1 if sample_valid), result_ovf<=ovf|new-sat; result_valid<=1
//       next cycle; acc/count/ovf <= 0 (new period starts empty).
//    3) sample_valid=1 only: acc/count/ovf update as above.
//    4) else: hold; result_valid<=0.
//  - Latency: sample on dump cycle N appears in result at N+1 with
//    result_valid=1 for exactly cycle N+1. result* hold until next dump.
//  - Back-to-back dumps (N, N+1): two pulses; second result = sample at N+1
//    if valid, else 0 with count 0. Dump with no prior samples -> result 0,
//    count 0, ovf 0 (still pulses).
//  - No backpressure: consumer must capture result within the period.
// TESTING
//  1 reset mid-period: 5 samples of +3 then reset -> all outputs 0, next dump
//    after 2 samples of +1 gives result=2, count=2, ovf=0.
//  2 basic: IN_WIDTH=4, samples +7,-8,+3,-1 with dump on last -> next cycle
//    result=+1, result_count=4, result_ovf=0, result_valid high 1 cycle.
//  3 saturation: ACC_WIDTH=6, 6 samples of +7 (sum 42) then dump -> result=31,
//    result_ovf=1; next period 2 samples of -8 -> result=-16, ovf=0.
//  4 clear vs dump: 3 samples +2, then clear and dump same cycle -> no
//    result_valid, result* unchanged; next dump with 1 sample +5 -> result=5.
//  5 back-to-back dumps: dump at N (sample +4 valid), dump at N+1 (no sample)
//    -> pulses at N+1 (result=acc+4) and N+2 (result=0, count=0).
//  6 counter saturation: COUNT_WIDTH=3, 9 zero samples then dump -> count=7,
//    result_ovf=1, result=0.

Source files
------------

// File: rtl/integrate_dump.sv
// -----------------------------------------------------------------------------
// integrate_dump
//
// Integrate-and-dump accumulator for one correlator arm. Signed wiped-off
// samples are summed over one code period; a dump strobe closes the period,
// publishes the total, the sample count and a sticky saturation flag, and
// pulses result_valid for one cycle. The accumulator and the sample counter
// both saturate instead of wrapping. Either clamp marks the period as
// overflowed.
//
// Parameters
//   IN_WIDTH     width of the signed two's-complement input sample
//   ACC_WIDTH    width of the signed accumulator and result (> IN_WIDTH)
//   COUNT_WIDTH  width of the per-period sample counter
//
// Ports
//   clk           sample clock (single domain)
//   reset         asynchronous active-high reset; clears everything, no dump
//   clear         synchronous: discard the open period and restart it empty
//   sample_valid  sample qualifies this cycle
//   sample        signed input sample
//   dump          synchronous strobe: this cycle closes the period
//   result        signed sum of the last closed period (held)
//   result_count  number of samples in the last closed period (held)
//   result_ovf    saturation occurred in the last closed period (held)
//   result_valid  one-cycle pulse when result* were updated
// -----------------------------------------------------------------------------
module integrate_dump #(
  parameter int IN_WIDTH    = 4,
  parameter int ACC_WIDTH   = 20,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        sample_valid,
  input  logic signed [IN_WIDTH-1:0]  sample,
  input  logic                        dump,
  output logic signed [ACC_WIDTH-1:0] result,
  output logic [COUNT_WIDTH-1:0]      result_count,
  output logic                        result_ovf,
  output logic                        result_valid
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0]      CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // One guard bit above the accumulator: the sum of an in-range accumulator
  // and a narrower sample can never overflow ACC_WIDTH+1 bits.
  function automatic logic signed [ACC_WIDTH:0] widen_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [IN_WIDTH-1:0]  s
  );
    logic signed [ACC_WIDTH:0] a_x;
    logic signed [ACC_WIDTH:0] s_x;
    a_x = {a[ACC_WIDTH-1], a};
    s_x = {{(ACC_WIDTH+1-IN_WIDTH){s[IN_WIDTH-1]}}, s};
    return a_x + s_x;
  endfunction

  // Guard bit and top result bit disagree exactly when the wide sum is
  // outside the ACC_WIDTH signed range; the guard bit gives the direction.
  function automatic logic sat_flag(input logic signed [ACC_WIDTH:0] x);
    return x[ACC_WIDTH] ^ x[ACC_WIDTH-1];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
    input logic signed [ACC_WIDTH:0] x
  );
    logic signed [ACC_WIDTH-1:0] r;
    if (sat_flag(x)) r = x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else             r = x[ACC_WIDTH-1:0];
    return r;
  endfunction

  // Counter sticks at all-ones; an attempted increment there is an overflow.
  function automatic logic [COUNT_WIDTH-1:0] sat_cnt(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  function automatic logic cnt_flag(input logic [COUNT_WIDTH-1:0] c);
    return &c;
  endfunction

  // Open-period state
  logic signed [ACC_WIDTH-1:0] acc_p0;
  logic [COUNT_WIDTH-1:0]      cnt_p0;
  logic                        ovf_p0;

  // Closed-period results
  logic signed [ACC_WIDTH-1:0] res_p1;
  logic [COUNT_WIDTH-1:0]      res_cnt_p1;
  logic                        res_ovf_p1;
  logic                        vld_p1;

  // Open period including this cycle's sample (if any)
  logic signed [ACC_WIDTH:0]   sum_x;
  logic signed [ACC_WIDTH-1:0] nxt_acc;
  logic [COUNT_WIDTH-1:0]      nxt_cnt;
  logic                        nxt_ovf;

  always_comb begin
    sum_x   = widen_add(acc_p0, sample);
    nxt_acc = acc_p0;
    nxt_cnt = cnt_p0;
    nxt_ovf = ovf_p0;
    if (sample_valid) begin
      nxt_acc = sat_acc(sum_x);
      nxt_cnt = sat_cnt(cnt_p0);
      nxt_ovf = ovf_p0 | sat_flag(sum_x) | cnt_flag(cnt_p0);
    end
  end

  // ---- stage p0: accumulate / close period; stage p1: published result ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p0     <= '0;
      cnt_p0     <= '0;
      ovf_p0     <= 1'b0;
      res_p1     <= '0;
      res_cnt_p1 <= '0;
      res_ovf_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else if (clear) begin
      // Clear wins over a coincident sample and dump; results are untouched.
      acc_p0     <= '0;
      cnt_p0     <= '0;
      ovf_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else if (dump) begin
      res_p1     <= nxt_acc;
      res_cnt_p1 <= nxt_cnt;
      res_ovf_p1 <= nxt_ovf;
      vld_p1     <= 1'b1;
      acc_p0     <= '0;
      cnt_p0     <= '0;
      ovf_p0     <= 1'b0;
    end else begin
      acc_p0     <= nxt_acc;
      cnt_p0     <= nxt_cnt;
      ovf_p0     <= nxt_ovf;
      vld_p1     <= 1'b0;
    end
  end

  assign result       = res_p1;
  assign result_count = res_cnt_p1;
  assign result_ovf   = res_ovf_p1;
  assign result_valid = vld_p1;

endmodule

// File: tb/tb_integrate_dump.sv
module tb_integrate_dump;

  localparam int IW   = 4;
  localparam int AW   = 6;
  localparam int CW   = 3;
  localparam int AMAX = (1 << (AW-1)) - 1;
  localparam int AMIN = -(1 << (AW-1));
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clear = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [IW-1:0] sample = '0;
  logic                 dump = 1'b0;
  logic signed [AW-1:0] result;
  logic [CW-1:0]        result_count;
  logic                 result_ovf;
  logic                 result_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference: samples of the open period, plus the published values.
  int q[$];
  int exp_res = 0;
  int exp_cnt = 0;
  int exp_ovf = 0;
  int exp_vld = 0;

  integrate_dump #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
    .sample(sample), .dump(dump), .result(result), .result_count(result_count),
    .result_ovf(result_ovf), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_vld"}, {31'd0, result_valid}, exp_vld);
    check({tag, "_res"}, {{(32-AW){result[AW-1]}}, result}, exp_res);
    check({tag, "_cnt"}, {{(32-CW){1'b0}}, result_count}, exp_cnt);
    check({tag, "_ovf"}, {31'd0, result_ovf}, exp_ovf);
  endtask

  // Close a period: add its samples one by one with clamping, count with
  // saturation; any clamp marks the period overflowed.
  task automatic close_period();
    int a, c, o;
    a = 0; c = 0; o = 0;
    foreach (q[i]) begin
      a = a + q[i];
      if (a > AMAX) begin a = AMAX; o = 1; end
      if (a < AMIN) begin a = AMIN; o = 1; end
      if (c == CMAX) o = 1; else c = c + 1;
    end
    exp_res = a; exp_cnt = c; exp_ovf = o; exp_vld = 1;
    q.delete();
  endtask

  // One clock: drive inputs, take the edge, update the model, compare.
  task automatic cycle(input string tag, input bit clr, input bit sv,
                       input int s, input bit d);
    clear = clr; sample_valid = sv; sample = s[IW-1:0]; dump = d;
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete(); exp_vld = 0;
    end else if (d) begin
      if (sv) q.push_back(s);
      close_period();
    end else begin
      if (sv) q.push_back(s);
      exp_vld = 0;
    end
    clear = 0; sample_valid = 0; dump = 0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    q.delete();
    exp_res = 0; exp_cnt = 0; exp_ovf = 0; exp_vld = 0;
    check_outputs(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por");
    reset = 1'b0;

    // 1: reset mid-period
    repeat (5) cycle("t1_acc", 0, 1, 3, 0);
    do_reset("t1_rst");
    cycle("t1_s", 0, 1, 1, 0);
    cycle("t1_d", 0, 1, 1, 1);
    check("t1_res_const", {{(32-AW){result[AW-1]}}, result}, 2);
    check("t1_cnt_const", {{(32-CW){1'b0}}, result_count}, 2);

    // 2: basic
    cycle("t2_a", 0, 1, 7, 0);
    cycle("t2_b", 0, 1, -8, 0);
    cycle("t2_c", 0, 1, 3, 0);
    cycle("t2_d", 0, 1, -1, 1);
    check("t2_res_const", {{(32-AW){result[AW-1]}}, result}, 1);
    cycle("t2_idle", 0, 0, 0, 0);

    // 3: accumulator saturation, then a clean negative period
    repeat (5) cycle("t3_acc", 0, 1, 7, 0);
    cycle("t3_d", 0, 1, 7, 1);
    check("t3_res_const", {{(32-AW){result[AW-1]}}, result}, 31);
    check("t3_ovf_const", {31'd0, result_ovf}, 1);
    cycle("t3_n", 0, 1, -8, 0);
    cycle("t3_nd", 0, 1, -8, 1);
    check("t3_neg_const", {{(32-AW){result[AW-1]}}, result}, -16);

    // 4: clear wins over dump
    repeat (3) cycle("t4_acc", 0, 1, 2, 0);
    cycle("t4_cd", 1, 1, 1, 1);
    cycle("t4_d", 0, 1, 5, 1);
    check("t4_res_const", {{(32-AW){result[AW-1]}}, result}, 5);

    // 5: back-to-back dumps
    cycle("t5_a", 0, 1, 3, 0);
    cycle("t5_d1", 0, 1, 4, 1);
    cycle("t5_d2", 0, 0, 0, 1);
    check("t5_cnt_const", {{(32-CW){1'b0}}, result_count}, 0);
    cycle("t5_idle", 0, 0, 0, 0);

    // 6: counter saturation
    repeat (8) cycle("t6_acc", 0, 1, 0, 0);
    cycle("t6_d", 0, 1, 0, 1);
    check("t6_cnt_const", {{(32-CW){1'b0}}, result_count}, 7);
    check("t6_ovf_const", {31'd0, result_ovf}, 1);

    // Randomized traffic, with occasional clear and async reset
    for (int i = 0; i < 400; i++) begin
      int v;
      v = int'($urandom_range(0, 15));
      if (v >= 8) v = v - 16;
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      cycle("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            v, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
